// File: rtl/jtag_tap_sampled_if.sv
// JTAG link between a driver (master) and the TAP responder (slave).
interface jtag_tap_sampled_if;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;

  modport master (output tck, tms, tdi, input tdo, tdo_oe);
  modport slave  (input tck, tms, tdi, output tdo, tdo_oe);
endinterface

// File: rtl/jtag_tap_sampled.sv
// Oversampled JTAG TAP: tck/tms/tdi synchronized into clk, full 1149.1 FSM, IDCODE/BYPASS/GPIO DRs.
// Define JTAG_USERCODE_EN to add the USERCODE instruction and its 32-bit DR.
module jtag_tap_sampled #(
  parameter int                   IR_LENGTH    = 4,
  parameter logic [31:0]          IDCODE_VALUE = 32'h149511C3,
  parameter logic [IR_LENGTH-1:0] IR_IDCODE    = 4'h1,
  parameter logic [IR_LENGTH-1:0] IR_BYPASS    = 4'hF,
  parameter logic [IR_LENGTH-1:0] IR_GPIO      = 4'hA,
  parameter int                   GPIO_W       = 3
`ifdef JTAG_USERCODE_EN
  ,
  parameter logic [IR_LENGTH-1:0] IR_USERCODE    = 4'h8,
  parameter logic [31:0]          USERCODE_VALUE = 32'h0000_0001
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  jtag_tap_sampled_if.slave     jtag,
  input  logic [GPIO_W:0]       gpio_in,
  output logic [GPIO_W-1:0]     gpio_out
);

  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0, EXIT1_DR = 4'h1, SHIFT_DR = 4'h2, PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4, UPD_DR   = 4'h5, CAP_DR   = 4'h6, SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8, EXIT1_IR = 4'h9, SHIFT_IR = 4'hA, PAUSE_IR = 4'hB,
    RTI      = 4'hC, UPD_IR   = 4'hD, CAP_IR   = 4'hE, TLR      = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_GPIO, SEL_USER} dr_sel_e;

  logic tck_s1_q, tck_s2_q, tck_hist_q, tms_s1_q, tms_s2_q, tdi_s1_q, tdi_s2_q;
  logic seen_q, armed_q, armed_d;
  logic tck_rise, tck_fall;

  // A tck already high when reset drops must be seen low once before any rise counts.
  assign armed_d  = armed_q | (seen_q & ~tck_s1_q);
  assign tck_rise = tck_s2_q & ~tck_hist_q & armed_q;
  assign tck_fall = ~tck_s2_q & tck_hist_q;

  // NOTE: sequential state uses non-blocking assignments so every FF samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      {tck_s1_q, tck_s2_q, tck_hist_q} <= '0;
      {tms_s1_q, tms_s2_q, tdi_s1_q, tdi_s2_q} <= '0;
      seen_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      tck_s1_q   <= jtag.tck;
      tck_s2_q   <= tck_s1_q;
      tck_hist_q <= tck_s2_q;
      tms_s1_q   <= jtag.tms;
      tms_s2_q   <= tms_s1_q;
      tdi_s1_q   <= jtag.tdi;
      tdi_s2_q   <= tdi_s1_q;
      seen_q     <= 1'b1;
      armed_q    <= armed_d;
    end
  end

  tap_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= TLR;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      unique case (state_q)
        TLR:      state_d = tms_s2_q ? TLR      : RTI;
        RTI:      state_d = tms_s2_q ? SEL_DR   : RTI;
        SEL_DR:   state_d = tms_s2_q ? SEL_IR   : CAP_DR;
        CAP_DR:   state_d = tms_s2_q ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state_d = tms_s2_q ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state_d = tms_s2_q ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_d = tms_s2_q ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state_d = tms_s2_q ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state_d = tms_s2_q ? SEL_DR   : RTI;
        SEL_IR:   state_d = tms_s2_q ? TLR      : CAP_IR;
        CAP_IR:   state_d = tms_s2_q ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state_d = tms_s2_q ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state_d = tms_s2_q ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_d = tms_s2_q ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state_d = tms_s2_q ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state_d = tms_s2_q ? SEL_DR   : RTI;
        default:  state_d = TLR;
      endcase
    end
  end

  logic cap_ir, shift_ir, upd_ir, cap_dr, shift_dr, upd_dr;

  always_comb begin
    cap_ir   = (state_q == CAP_IR);
    shift_ir = (state_q == SHIFT_IR);
    upd_ir   = (state_q == UPD_IR);
    cap_dr   = (state_q == CAP_DR);
    shift_dr = (state_q == SHIFT_DR);
    upd_dr   = (state_q == UPD_DR);
  end

  logic [IR_LENGTH-1:0] ir_q, ir_sr_q;
  logic                 bypass_q;
  logic [GPIO_W:0]      gpio_sr_q;
  logic [31:0]          id_sr_q, id_capture;
  logic [GPIO_W-1:0]    gpio_out_q;
  logic                 tdo_q, tdo_oe_q;
  dr_sel_e              dr_sel;
  logic                 dr_lsb;

  // Any IR value without its own DR falls back to BYPASS.
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_q == IR_IDCODE) dr_sel = SEL_IDCODE;
    if (ir_q == IR_GPIO)   dr_sel = SEL_GPIO;
`ifdef JTAG_USERCODE_EN
    if (ir_q == IR_USERCODE) dr_sel = SEL_USER;
`endif
  end

`ifdef JTAG_USERCODE_EN
  assign id_capture = (dr_sel == SEL_USER) ? USERCODE_VALUE : IDCODE_VALUE;
`else
  assign id_capture = IDCODE_VALUE;
`endif

  always_comb begin
    unique case (dr_sel)
      SEL_IDCODE, SEL_USER: dr_lsb = id_sr_q[0];
      SEL_GPIO:             dr_lsb = gpio_sr_q[0];
      default:              dr_lsb = bypass_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q       <= IR_IDCODE;
      ir_sr_q    <= '0;
      bypass_q   <= 1'b0;
      gpio_sr_q  <= '0;
      id_sr_q    <= '0;
      gpio_out_q <= '0;
      tdo_q      <= 1'b0;
      tdo_oe_q   <= 1'b0;
    end else begin
      if (tck_rise) begin
        if (cap_ir)   ir_sr_q <= IR_LENGTH'(4'b0101);
        if (shift_ir) ir_sr_q <= {tdi_s2_q, ir_sr_q[IR_LENGTH-1:1]};
        if (upd_ir)   ir_q    <= ir_sr_q;
        if (state_d == TLR) ir_q <= IR_IDCODE;
        if (cap_dr) begin
          unique case (dr_sel)
            SEL_IDCODE, SEL_USER: id_sr_q   <= id_capture;
            SEL_GPIO:             gpio_sr_q <= gpio_in;
            default:              bypass_q  <= 1'b0;
          endcase
        end
        if (shift_dr) begin
          unique case (dr_sel)
            SEL_IDCODE, SEL_USER: id_sr_q   <= {tdi_s2_q, id_sr_q[31:1]};
            SEL_GPIO:             gpio_sr_q <= {tdi_s2_q, gpio_sr_q[GPIO_W:1]};
            default:              bypass_q  <= tdi_s2_q;
          endcase
        end
        if (upd_dr && dr_sel == SEL_GPIO) gpio_out_q <= gpio_sr_q[GPIO_W-1:0];
      end
      if (tck_fall) begin
        tdo_oe_q <= shift_ir | shift_dr;
        if (shift_ir)      tdo_q <= ir_sr_q[0];
        else if (shift_dr) tdo_q <= dr_lsb;
      end
    end
  end

  assign jtag.tdo    = tdo_q;
  assign jtag.tdo_oe = tdo_oe_q;
  assign gpio_out    = gpio_out_q;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed bench for jtag_tap_sampled: bit-bangs tck/tms/tdi and checks tdo, tdo_oe, gpio_out.
module tb_jtag_tap_sampled;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] gpio_in;
  logic [2:0] gpio_out;

  jtag_tap_sampled_if jif ();

  jtag_tap_sampled dut (
    .clk      (clk),
    .reset    (reset),
    .jtag     (jif.slave),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One tck period; returns tdo/tdo_oe as seen just before the rising edge.
  task automatic tck_step(input logic tms_v, input logic tdi_v, output logic tdo_v, output logic oe_v);
    jif.tms = tms_v;
    jif.tdi = tdi_v;
    wait_clk(4);
    tdo_v = jif.tdo;
    oe_v  = jif.tdo_oe;
    jif.tck = 1'b1;
    wait_clk(8);
    jif.tck = 1'b0;
    wait_clk(4);
  endtask

  task automatic move(input logic tms_v);
    logic b, o;
    tck_step(tms_v, 1'b0, b, o);
  endtask

  task automatic shift_bits(input int n, input logic [31:0] din, input bit last_exit,
                            output logic [31:0] dout, output logic oe_all);
    logic b, o;
    dout   = '0;
    oe_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      tck_step(last_exit && (i == n - 1), din[i], b, o);
      dout[i] = b;
      oe_all  = oe_all & o;
    end
  endtask

  task automatic to_tlr();
    repeat (5) move(1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, d_lo, d_hi;
    logic        oe_all, b, o, pause_oe;

    jif.tck = 1'b0;
    jif.tms = 1'b1;
    jif.tdi = 1'b0;
    gpio_in = 4'b0000;
    reset   = 1'b1;
    wait_clk(5);
    check("rst_tdo",    32'(jif.tdo),     32'h0);
    check("rst_tdo_oe", 32'(jif.tdo_oe),  32'h0);
    check("rst_gpio",   32'(gpio_out),    32'h0);
    check("rst_state",  32'(dut.state_q), 32'hF);
    check("rst_ir",     32'(dut.ir_q),    32'h1);
    reset = 1'b0;
    wait_clk(5);

    // IDCODE readback straight out of reset
    to_tlr();
    move(1'b0); move(1'b1); move(1'b0); move(1'b0);
    shift_bits(32, 32'h0, 1'b1, d, oe_all);
    check("idcode",     d,          32'h149511C3);
    check("idcode_oe",  32'(oe_all), 32'h1);
    tck_step(1'b1, 1'b0, b, o);
    check("oe_after_exit", 32'(o), 32'h0);

    // IR capture pattern and BYPASS
    move(1'b1); move(1'b1); move(1'b0); move(1'b0);
    shift_bits(4, 32'hF, 1'b1, d, oe_all);
    check("ir_capture", d, 32'h5);
    check("ir_oe",      32'(oe_all), 32'h1);
    move(1'b1); move(1'b0);
    check("ir_bypass", 32'(dut.ir_q), 32'hF);
    move(1'b1); move(1'b0); move(1'b0);
    shift_bits(9, 32'h0C1, 1'b1, d, oe_all);
    check("bypass_stream", d, 32'h182);

    // GPIO capture / update
    move(1'b1); move(1'b1); move(1'b1); move(1'b0); move(1'b0);
    shift_bits(4, 32'hA, 1'b1, d, oe_all);
    move(1'b1); move(1'b0);
    gpio_in = 4'b1001;
    move(1'b1); move(1'b0); move(1'b0);
    shift_bits(4, 32'h6, 1'b1, d, oe_all);
    check("gpio_capture", d, 32'h9);
    check("gpio_pre_upd", 32'(gpio_out), 32'h0);
    move(1'b1);
    check("gpio_in_upd",  32'(gpio_out), 32'h0);
    move(1'b0);
    check("gpio_updated", 32'(gpio_out), 32'h6);

    // TLR via tms: IR back to IDCODE, gpio_out held
    to_tlr();
    check("tlr_state", 32'(dut.state_q), 32'hF);
    check("tlr_ir",    32'(dut.ir_q),    32'h1);
    check("tlr_gpio",  32'(gpio_out),    32'h6);

    // IDCODE split by Pause-DR / Exit2-DR
    move(1'b0); move(1'b1); move(1'b0); move(1'b0);
    shift_bits(16, 32'h0, 1'b1, d_lo, oe_all);
    move(1'b0);
    pause_oe = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tck_step(1'b0, 1'b1, b, o);
      pause_oe = pause_oe | o;
    end
    move(1'b1); move(1'b0);
    shift_bits(16, 32'h0, 1'b1, d_hi, oe_all);
    check("pause_idcode", {d_hi[15:0], d_lo[15:0]}, 32'h149511C3);
    check("pause_oe",     32'(pause_oe), 32'h0);

    // Reset mid-Shift-DR with tck held high
    to_tlr();
    move(1'b0); move(1'b1); move(1'b0); move(1'b0);
    shift_bits(5, 32'h0, 1'b0, d, oe_all);
    jif.tms = 1'b0;
    wait_clk(3);
    jif.tck = 1'b1;
    reset   = 1'b1;
    wait_clk(6);
    reset = 1'b0;
    wait_clk(10);
    check("mid_rst_state",  32'(dut.state_q), 32'hF);
    check("mid_rst_ir",     32'(dut.ir_q),    32'h1);
    check("mid_rst_gpio",   32'(gpio_out),    32'h0);
    check("mid_rst_tdo_oe", 32'(jif.tdo_oe),  32'h0);
    jif.tck = 1'b0;
    wait_clk(8);
    check("no_spurious_rise", 32'(dut.state_q), 32'hF);
    move(1'b0); move(1'b1); move(1'b0); move(1'b0);
    shift_bits(32, 32'h0, 1'b1, d, oe_all);
    check("idcode_after_rst", d, 32'h149511C3);

    // IR = 8: USERCODE when enabled, otherwise BYPASS
    move(1'b1); move(1'b1); move(1'b1); move(1'b0); move(1'b0);
    shift_bits(4, 32'h8, 1'b1, d, oe_all);
    move(1'b1); move(1'b0);
    move(1'b1); move(1'b0); move(1'b0);
`ifdef JTAG_USERCODE_EN
    shift_bits(32, 32'h0, 1'b1, d, oe_all);
    check("usercode", d, 32'h0000_0001);
`else
    shift_bits(3, 32'h3, 1'b1, d, oe_all);
    check("ir8_bypass", d, 32'h6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
